// File: rtl/lut_layer_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : lut_layer_pipe
//  Description : Pipelined layer of LUT neurons. Each of N_NEURON neurons maps
//                its own IN_W-bit slice of the input word to an OUT_W-bit
//                result through a run-time loadable truth table held in
//                distributed RAM. A LOAD/RUN/DRAIN state machine keeps table
//                writes apart from streaming traffic.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk           in   1                 rising-edge clock
//   rst_n         in   1                 asynchronous active-low reset
//   i_in_valid    in   1                 input word valid
//   o_in_ready    out  1                 input accepted on valid && ready
//   i_in_data     in   N_NEURON*IN_W     neuron k address = [k*IN_W +: IN_W]
//   o_out_valid   out  1                 output word valid
//   i_out_ready   in   1                 downstream accepts output
//   o_out_data    out  N_NEURON*OUT_W    neuron k result = [k*OUT_W +: OUT_W]
//   i_cfg_start   in   1                 request table reload (RUN only)
//   i_cfg_we      in   1                 table write strobe (LOAD only)
//   i_cfg_neuron  in   NID_W             neuron index to write
//   i_cfg_addr    in   IN_W              table entry to write
//   i_cfg_wdata   in   OUT_W             table entry value
//   i_cfg_commit  in   1                 leave LOAD and enter RUN
//   o_cfg_count   out  IN_W+NID_W+1      accepted writes since LOAD entry
//   o_state_run   out  1                 high while in RUN
// ============================================================================
module lut_layer_pipe #(
   parameter int IN_W     = 8,
   parameter int OUT_W    = 1,
   parameter int N_NEURON = 4,
   parameter int NID_W    = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   input  logic [N_NEURON*IN_W-1:0]    i_in_data,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic [N_NEURON*OUT_W-1:0]   o_out_data,
   input  logic                        i_cfg_start,
   input  logic                        i_cfg_we,
   input  logic [NID_W-1:0]            i_cfg_neuron,
   input  logic [IN_W-1:0]             i_cfg_addr,
   input  logic [OUT_W-1:0]            i_cfg_wdata,
   input  logic                        i_cfg_commit,
   output logic [IN_W+NID_W:0]         o_cfg_count,
   output logic                        o_state_run
);

   localparam int                 c_DEPTH   = 1 << IN_W;
   localparam int                 c_CNT_W   = IN_W + NID_W + 1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
   // Widened by one bit so N_NEURON == 2**NID_W is still representable.
   localparam logic [NID_W:0]     c_NNEUR   = (NID_W+1)'(N_NEURON);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                      r_state;
   logic                        r_state_run;
   logic [c_CNT_W-1:0]          r_cfg_count;

   logic                        r_s1_valid;
   logic [N_NEURON*IN_W-1:0]    r_s1_data;
   logic                        r_out_valid;
   logic [N_NEURON*OUT_W-1:0]   r_out_data;

   logic                        w_adv1;
   logic                        w_adv2;
   logic                        w_accept;
   logic                        w_wr_ok;
   logic                        w_pipe_empty;
   logic [N_NEURON*OUT_W-1:0]   w_lut;

   // ------------------------------------------------------------------------
   // Handshake. S2 frees when empty or drained this cycle; S1 frees when
   // empty or when it can hand its word to S2. Ready is combinational on
   // i_out_ready so a stream can move one word per cycle.
   // ------------------------------------------------------------------------
   assign w_adv2       = !r_out_valid || i_out_ready;
   assign w_adv1       = !r_s1_valid  || w_adv2;
   assign o_in_ready   = r_state_run && w_adv1;
   assign w_accept     = i_in_valid && o_in_ready;
   assign w_pipe_empty = !r_s1_valid && !r_out_valid;

   // A write counts only in LOAD and only for an existing neuron.
   assign w_wr_ok = (r_state == ST_LOAD) && i_cfg_we &&
                    ({1'b0, i_cfg_neuron} < c_NNEUR);

   // ------------------------------------------------------------------------
   // Per-neuron truth tables: synchronous write, asynchronous read of the
   // S1 slice. Contents deliberately survive reset.
   // ------------------------------------------------------------------------
   generate
      for (genvar k = 0; k < N_NEURON; k++) begin : g_neuron
         logic [OUT_W-1:0] r_tbl [0:c_DEPTH-1];
         logic             w_we;

         assign w_we = w_wr_ok && (i_cfg_neuron == NID_W'(k));

         always_ff @(posedge clk) begin
            if (w_we) begin
               r_tbl[i_cfg_addr] <= i_cfg_wdata;
            end
         end

         assign w_lut[k*OUT_W +: OUT_W] = r_tbl[r_s1_data[k*IN_W +: IN_W]];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Two-stage pipeline: S1 holds the input word, S2 the table results.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_adv1) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
               r_s1_data <= i_in_data;
            end
         end
         if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            // Data only moves with a valid word, so a bubble leaves the
            // last result on the bus instead of a stale table read.
            if (r_s1_valid) begin
               r_out_data <= w_lut;
            end
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs.
   //  LOAD : table writes allowed; commit moves to RUN (a same-cycle write
   //         still lands because the table port does not look at commit).
   //  RUN  : traffic flows; cfg_start closes the input and moves to DRAIN.
   //  DRAIN: input closed until both stages are empty, then back to LOAD
   //         with the write counter cleared.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_LOAD;
         r_state_run <= 1'b0;
         r_cfg_count <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_wr_ok && (r_cfg_count != c_CNT_MAX)) begin
                  r_cfg_count <= r_cfg_count + 1'b1;
               end
               if (i_cfg_commit) begin
                  r_state     <= ST_RUN;
                  r_state_run <= 1'b1;
               end
            end
            ST_RUN: begin
               if (i_cfg_start) begin
                  r_state     <= ST_DRAIN;
                  r_state_run <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (w_pipe_empty) begin
                  r_state     <= ST_LOAD;
                  r_cfg_count <= '0;
               end
            end
            default: begin
               r_state     <= ST_LOAD;
               r_state_run <= 1'b0;
               r_cfg_count <= '0;
            end
         endcase
      end
   end

   assign o_cfg_count = r_cfg_count;
   assign o_state_run = r_state_run;

endmodule
`default_nettype wire

// File: tb/tb_lut_layer_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_layer_pipe
//  Description : Directed self-checking bench for lut_layer_pipe: table load,
//                streaming, backpressure, drain, partial reload and
//                asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_layer_pipe;

   localparam int IN_W  = 8;
   localparam int OUT_W = 1;
   localparam int NN    = 4;
   localparam int NID_W = 3;
   localparam int CW    = IN_W + NID_W + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_in_valid;
   logic              o_in_ready;
   logic [NN*IN_W-1:0] i_in_data;
   logic              o_out_valid;
   logic              i_out_ready;
   logic [NN*OUT_W-1:0] o_out_data;
   logic              i_cfg_start;
   logic              i_cfg_we;
   logic [NID_W-1:0]  i_cfg_neuron;
   logic [IN_W-1:0]   i_cfg_addr;
   logic [OUT_W-1:0]  i_cfg_wdata;
   logic              i_cfg_commit;
   logic [CW-1:0]     o_cfg_count;
   logic              o_state_run;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference copy of the truth tables, filled as the bench writes them.
   logic exp_tbl [NN][256];

   always #5 clk = ~clk;

   lut_layer_pipe #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .N_NEURON (NN),
      .NID_W    (NID_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_in_data    (i_in_data),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_out_data   (o_out_data),
      .i_cfg_start  (i_cfg_start),
      .i_cfg_we     (i_cfg_we),
      .i_cfg_neuron (i_cfg_neuron),
      .i_cfg_addr   (i_cfg_addr),
      .i_cfg_wdata  (i_cfg_wdata),
      .i_cfg_commit (i_cfg_commit),
      .o_cfg_count  (o_cfg_count),
      .o_state_run  (o_state_run)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] model(input logic [31:0] w);
      logic [3:0] r;
      logic [7:0] a;
      for (int k = 0; k < NN; k++) begin
         a    = w[k*8 +: 8];
         r[k] = exp_tbl[k][a];
      end
      return r;
   endfunction

   // Pushes one word through with out_ready=1 and returns the result word.
   // ok=0 means a bounded wait ran out.
   task automatic send_one(input logic [31:0] w, output logic ok, output logic [3:0] got);
      int budget;
      ok  = 1'b0;
      got = '0;
      i_in_valid = 1'b1;
      i_in_data  = w;
      #1;
      budget = 0;
      while (!o_in_ready && budget < 20) begin
         tick;
         budget++;
      end
      if (!o_in_ready) begin
         i_in_valid = 1'b0;
         return;
      end
      tick;
      i_in_valid = 1'b0;
      budget = 0;
      while (!o_out_valid && budget < 20) begin
         tick;
         budget++;
      end
      if (!o_out_valid) return;
      got = o_out_data;
      ok  = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      rst_n        = 1'b0;
      i_in_valid   = 1'b0;
      i_in_data    = '0;
      i_out_ready  = 1'b1;
      i_cfg_start  = 1'b0;
      i_cfg_we     = 1'b0;
      i_cfg_neuron = '0;
      i_cfg_addr   = '0;
      i_cfg_wdata  = '0;
      i_cfg_commit = 1'b0;
      repeat (3) tick;
      n_tests++;
      if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", o_in_ready); end
      n_tests++;
      if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", o_out_valid); end
      n_tests++;
      if (o_out_data !== 4'b0000) begin n_fail++; $display("FAIL reset_out_data: got %b want 0000", o_out_data); end
      n_tests++;
      if (o_cfg_count !== 12'd0) begin n_fail++; $display("FAIL reset_cfg_count: got %0d want 0", o_cfg_count); end
      n_tests++;
      if (o_state_run !== 1'b0) begin n_fail++; $display("FAIL reset_state_run: got %b want 0", o_state_run); end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_load;
      logic [7:0] av;
      logic       v;
      for (int n = 0; n < NN; n++) begin
         for (int a = 0; a < 256; a++) begin
            av = 8'(a);
            v  = (n == 0) ? (av[1] | (av[0] & av[6])) : 1'b0;
            exp_tbl[n][a] = v;
            i_cfg_we     = 1'b1;
            i_cfg_neuron = 3'(n);
            i_cfg_addr   = av;
            i_cfg_wdata  = v;
            tick;
         end
      end
      i_cfg_we = 1'b0;
      n_tests++;
      if (o_cfg_count !== 12'd1024) begin n_fail++; $display("FAIL load_count: got %0d want 1024", o_cfg_count); end
      n_tests++;
      if (o_state_run !== 1'b0) begin n_fail++; $display("FAIL load_not_run: got %b want 0", o_state_run); end
      i_cfg_commit = 1'b1;
      tick;
      i_cfg_commit = 1'b0;
      n_tests++;
      if (o_state_run !== 1'b1) begin n_fail++; $display("FAIL commit_run: got %b want 1", o_state_run); end
      n_tests++;
      if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL commit_in_ready: got %b want 1", o_in_ready); end
   endtask

   task automatic test_stream;
      i_out_ready = 1'b1;
      i_in_valid  = 1'b1;
      i_in_data   = 32'h00000002;
      #1;
      n_tests++;
      if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready: got %b want 1", o_in_ready); end
      tick;
      i_in_data = 32'h00000001;
      n_tests++;
      if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %b want 0", o_out_valid); end
      tick;
      i_in_valid = 1'b0;
      n_tests++;
      if (o_out_valid !== 1'b1 || o_out_data !== 4'b0001) begin
         n_fail++; $display("FAIL stream_word0: got v=%b d=%b want v=1 d=0001", o_out_valid, o_out_data);
      end
      tick;
      n_tests++;
      if (o_out_valid !== 1'b1 || o_out_data !== 4'b0000) begin
         n_fail++; $display("FAIL stream_word1: got v=%b d=%b want v=1 d=0000", o_out_valid, o_out_data);
      end
      tick;
      n_tests++;
      if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle: got %b want 0", o_out_valid); end
   endtask

   task automatic test_backpressure;
      logic [31:0] w [5];
      logic [3:0]  rcv [5];
      int          idx;
      int          nr;
      int          acc;
      logic        take;
      w[0] = 32'h00000002; w[1] = 32'h00000001; w[2] = 32'h00000003;
      w[3] = 32'h00000041; w[4] = 32'h00000040;
      idx = 0; nr = 0; acc = 0;
      i_out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         i_in_valid = 1'b1;
         i_in_data  = w[idx];
         #1;
         take = o_in_ready;
         if (o_out_valid) begin
            n_tests++;
            if (o_out_data !== model(w[0])) begin
               n_fail++; $display("FAIL bp_hold: cycle %0d got %b want %b", c, o_out_data, model(w[0]));
            end
         end
         tick;
         if (take) begin acc++; idx++; end
      end
      n_tests++;
      if (acc != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", acc); end
      i_out_ready = 1'b1;
      for (int c = 0; c < 30 && nr < 5; c++) begin
         i_in_valid = (idx < 5);
         i_in_data  = (idx < 5) ? w[idx] : 32'h0;
         #1;
         take = i_in_valid && o_in_ready;
         if (o_out_valid) begin
            rcv[nr] = o_out_data;
            nr++;
         end
         tick;
         if (take) idx++;
      end
      i_in_valid = 1'b0;
      n_tests++;
      if (nr != 5) begin n_fail++; $display("FAIL bp_count: got %0d words want 5", nr); end
      for (int i = 0; i < nr; i++) begin
         n_tests++;
         if (rcv[i] !== model(w[i])) begin
            n_fail++; $display("FAIL bp_order: word %0d got %b want %b", i, rcv[i], model(w[i]));
         end
      end
      #1;
      n_tests++;
      if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got out_valid %b want 0", o_out_valid); end
   endtask

   task automatic test_drain;
      int budget;
      i_out_ready = 1'b1;
      i_in_valid  = 1'b1;
      i_in_data   = 32'h00000003;
      tick;
      // Second word plus reload request and a table write while in RUN.
      i_in_data    = 32'h00000040;
      i_cfg_start  = 1'b1;
      i_cfg_we     = 1'b1;
      i_cfg_neuron = 3'd0;
      i_cfg_addr   = 8'h02;
      i_cfg_wdata  = 1'b0;
      tick;
      i_cfg_start = 1'b0;
      i_in_data   = 32'h00000002;
      #1;
      n_tests++;
      if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %b want 0", o_in_ready); end
      n_tests++;
      if (o_out_valid !== 1'b1 || o_out_data !== 4'b0001) begin
         n_fail++; $display("FAIL drain_word0: got v=%b d=%b want v=1 d=0001", o_out_valid, o_out_data);
      end
      tick;
      n_tests++;
      if (o_out_valid !== 1'b1 || o_out_data !== 4'b0000) begin
         n_fail++; $display("FAIL drain_word1: got v=%b d=%b want v=1 d=0000", o_out_valid, o_out_data);
      end
      i_in_valid = 1'b0;
      i_cfg_we   = 1'b0;
      tick;
      n_tests++;
      if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_extra: got %b want 0", o_out_valid); end
      budget = 0;
      while (o_cfg_count !== 12'd0 && budget < 10) begin
         tick;
         budget++;
      end
      n_tests++;
      if (o_cfg_count !== 12'd0) begin n_fail++; $display("FAIL drain_to_load: cfg_count %0d want 0", o_cfg_count); end
      n_tests++;
      if (o_state_run !== 1'b0 || o_in_ready !== 1'b0) begin
         n_fail++; $display("FAIL drain_load_state: run=%b ready=%b want 0 0", o_state_run, o_in_ready);
      end
   endtask

   task automatic test_partial_load;
      logic       ok;
      logic [3:0] got;
      i_cfg_we     = 1'b1;
      i_cfg_neuron = 3'd2;
      i_cfg_addr   = 8'hFF;
      i_cfg_wdata  = 1'b1;
      exp_tbl[2][255] = 1'b1;
      tick;
      i_cfg_neuron = 3'd7;
      tick;
      i_cfg_we = 1'b0;
      n_tests++;
      if (o_cfg_count !== 12'd1) begin n_fail++; $display("FAIL partial_count: got %0d want 1", o_cfg_count); end
      i_cfg_commit = 1'b1;
      tick;
      i_cfg_commit = 1'b0;
      n_tests++;
      if (o_state_run !== 1'b1) begin n_fail++; $display("FAIL partial_run: got %b want 1", o_state_run); end
      send_one(32'h00FF0000, ok, got);
      n_tests++;
      if (!ok || got !== 4'b0100) begin n_fail++; $display("FAIL partial_n2: ok=%b got %b want 0100", ok, got); end
      send_one(32'h00FF0002, ok, got);
      n_tests++;
      if (!ok || got !== 4'b0101) begin n_fail++; $display("FAIL partial_untouched: ok=%b got %b want 0101", ok, got); end
      send_one(32'hFF000000, ok, got);
      n_tests++;
      if (!ok || got !== 4'b0000) begin n_fail++; $display("FAIL partial_invalid_nid: ok=%b got %b want 0000", ok, got); end
   endtask

   task automatic test_async_reset;
      logic       ok;
      logic [3:0] got;
      i_out_ready = 1'b0;
      i_in_valid  = 1'b1;
      i_in_data   = 32'h00FF0002;
      tick;
      i_in_valid = 1'b0;
      tick;
      n_tests++;
      if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_setup: out_valid %b want 1", o_out_valid); end
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (o_out_valid !== 1'b0 || o_out_data !== 4'b0000) begin
         n_fail++; $display("FAIL arst_out: v=%b d=%b want 0 0000", o_out_valid, o_out_data);
      end
      n_tests++;
      if (o_state_run !== 1'b0 || o_in_ready !== 1'b0 || o_cfg_count !== 12'd0) begin
         n_fail++; $display("FAIL arst_fsm: run=%b ready=%b cnt=%0d want 0 0 0", o_state_run, o_in_ready, o_cfg_count);
      end
      tick;
      tick;
      rst_n       = 1'b1;
      i_out_ready = 1'b1;
      tick;
      n_tests++;
      if (o_out_valid !== 1'b0 || o_state_run !== 1'b0) begin
         n_fail++; $display("FAIL arst_release: v=%b run=%b want 0 0", o_out_valid, o_state_run);
      end
      i_cfg_commit = 1'b1;
      tick;
      i_cfg_commit = 1'b0;
      send_one(32'h00FF0002, ok, got);
      n_tests++;
      if (!ok || got !== 4'b0101) begin n_fail++; $display("FAIL arst_tbl_a: ok=%b got %b want 0101", ok, got); end
      send_one(32'h00000003, ok, got);
      n_tests++;
      if (!ok || got !== 4'b0001) begin n_fail++; $display("FAIL arst_tbl_b: ok=%b got %b want 0001", ok, got); end
   endtask

   initial begin
      test_reset;
      test_load;
      test_stream;
      test_backpressure;
      test_drain;
      test_partial_load;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
